// File: rtl/popcount_frame_acc_if.sv
// Handshake bundle for popcount_frame_acc: per-byte ones-count beats in and
// per-frame results out, each with its own valid/ready pair.
interface popcount_frame_acc_if #(
  parameter int SUM_W = 12
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_count;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [7:0]       out_bytes;
  logic [3:0]       out_max;
  logic             out_err;

  modport master (
    output in_valid, in_count, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_bytes, out_max, out_err
  );

  modport slave (
    input  in_valid, in_count, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_bytes, out_max, out_err
  );
endinterface

// File: rtl/popcount_frame_acc.sv
// Accumulates per-byte ones-counts into frame totals (sum, beats, max, error)
// and holds each frame result until the consumer accepts it.
module popcount_frame_acc #(
  parameter int FRAME_LEN = 16,
  parameter int SUM_W     = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  popcount_frame_acc_if.slave  bus
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [7:0] FRAME_LEN_B = 8'(FRAME_LEN);

  // Counts above 8 cannot come from a byte; saturate them so the sum stays bounded.
  function automatic logic [3:0] clamp_count(input logic [3:0] cnt);
    if (cnt > 4'd8) begin
      return 4'd8;
    end else begin
      return cnt;
    end
  endfunction

  state_e           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [7:0]       bytes_q, bytes_d;
  logic [3:0]       max_q, max_d;
  logic             err_q, err_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             xfer_s;
  logic [3:0]       clamped_s;

  // Next-state and accumulator update.
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    bytes_d   = bytes_q;
    max_d     = max_q;
    err_d     = err_q;
    xfer_s    = bus.in_valid && in_ready_q;
    clamped_s = clamp_count(bus.in_count);
    case (state_q)
      ACC: begin
        if (xfer_s) begin
          sum_d   = sum_q + SUM_W'(clamped_s);
          bytes_d = bytes_q + 8'd1;
          max_d   = (clamped_s > max_q) ? clamped_s : max_q;
          err_d   = err_q | (bus.in_count > 4'd8);
          if (bus.in_last || (bytes_q + 8'd1 == FRAME_LEN_B)) begin
            state_d = HOLD;
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = ACC;
        end
      end
      HOLD: begin
        if (bus.out_ready && out_valid_q) begin
          state_d = ACC;
          sum_d   = {SUM_W{1'b0}};
          bytes_d = 8'd0;
          max_d   = 4'd0;
          err_d   = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = ACC;
        sum_d   = {SUM_W{1'b0}};
        bytes_d = 8'd0;
        max_d   = 4'd0;
        err_d   = 1'b0;
      end
    endcase
    // Handshake flags are registered copies of the next state so that they
    // read 0 while reset is held and 1 on the first cycle after it.
    in_ready_d  = (state_d == ACC);
    out_valid_d = (state_d == HOLD);
  end

  // State and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      sum_q       <= {SUM_W{1'b0}};
      bytes_q     <= 8'd0;
      max_q       <= 4'd0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      bytes_q     <= bytes_d;
      max_q       <= max_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_bytes = bytes_q;
  assign bus.out_max   = max_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_popcount_frame_acc.sv
// Directed bench for popcount_frame_acc: a FRAME_LEN=16 instance for the main
// frame scenarios and a FRAME_LEN=1 instance for the single-beat stream.
module tb_popcount_frame_acc;

  logic clk;
  logic rst;
  int   checks_cnt;
  int   fail_cnt;

  popcount_frame_acc_if #(.SUM_W(12)) a_if ();
  popcount_frame_acc_if #(.SUM_W(12)) b_if ();

  popcount_frame_acc #(.FRAME_LEN(16), .SUM_W(12)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  popcount_frame_acc #(.FRAME_LEN(1), .SUM_W(12)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one beat, returns at the following negedge.
  task automatic beat(input logic [3:0] cnt, input logic last);
    chk("beat_in_ready", 32'(a_if.in_ready), 32'd1);
    a_if.in_valid = 1'b1;
    a_if.in_count = cnt;
    a_if.in_last  = last;
    @(posedge clk);
    @(negedge clk);
    a_if.in_valid = 1'b0;
    a_if.in_last  = 1'b0;
  endtask

  task automatic chk_result(input string tag, input int sum, input int nbytes,
                            input int mx, input int err);
    chk({tag, "_valid"}, 32'(a_if.out_valid), 32'd1);
    chk({tag, "_ready"}, 32'(a_if.in_ready), 32'd0);
    chk({tag, "_sum"},   32'(a_if.out_sum), 32'(sum));
    chk({tag, "_bytes"}, 32'(a_if.out_bytes), 32'(nbytes));
    chk({tag, "_max"},   32'(a_if.out_max), 32'(mx));
    chk({tag, "_err"},   32'(a_if.out_err), 32'(err));
  endtask

  // With out_ready=1 at a HOLD negedge: one edge later the block is back in ACC, cleared.
  task automatic chk_released(input string tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_rel_valid"}, 32'(a_if.out_valid), 32'd0);
    chk({tag, "_rel_ready"}, 32'(a_if.in_ready), 32'd1);
    chk({tag, "_rel_sum"},   32'(a_if.out_sum), 32'd0);
  endtask

  logic [3:0] b_vals [6];

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    rst = 1'b1;
    a_if.in_valid = 1'b0; a_if.in_count = 4'd0; a_if.in_last = 1'b0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_count = 4'd0; b_if.in_last = 1'b0; b_if.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(a_if.in_ready), 32'd0);
    chk("rst_out_valid", 32'(a_if.out_valid), 32'd0);
    chk("rst_sum",       32'(a_if.out_sum), 32'd0);
    chk("rst_bytes",     32'(a_if.out_bytes), 32'd0);
    chk("rst_max",       32'(a_if.out_max), 32'd0);
    chk("rst_err",       32'(a_if.out_err), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_ready", 32'(a_if.in_ready), 32'd1);

    // Full frame: 16 beats of 8
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 15; i++) beat(4'd8, 1'b0);
    chk("full_not_early", 32'(a_if.out_valid), 32'd0);
    beat(4'd8, 1'b0);
    chk_result("full", 128, 16, 8, 0);
    chk_released("full");

    // Early close: 3,5,1 with last; next frame starts from zero
    beat(4'd3, 1'b0);
    beat(4'd5, 1'b0);
    beat(4'd1, 1'b1);
    chk_result("early", 9, 3, 5, 0);
    chk_released("early");
    beat(4'd2, 1'b1);
    chk_result("early_next", 2, 1, 2, 0);
    chk_released("early_next");

    // Backpressure: 15 beats of 4 then 7, held for 10 cycles with in_valid pushing
    a_if.out_ready = 1'b0;
    for (int i = 0; i < 15; i++) beat(4'd4, 1'b0);
    beat(4'd7, 1'b0);
    a_if.in_valid = 1'b1;
    a_if.in_count = 4'd8;
    for (int i = 0; i < 10; i++) begin
      chk("bp_ready", 32'(a_if.in_ready), 32'd0);
      chk("bp_valid", 32'(a_if.out_valid), 32'd1);
      chk("bp_sum",   32'(a_if.out_sum), 32'd67);
      chk("bp_bytes", 32'(a_if.out_bytes), 32'd16);
      chk("bp_max",   32'(a_if.out_max), 32'd7);
      @(posedge clk);
      @(negedge clk);
    end
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;
    chk_released("bp");

    // Illegal count: 2,2,12,2 closes with last
    beat(4'd2, 1'b0);
    beat(4'd2, 1'b0);
    beat(4'd12, 1'b0);
    beat(4'd2, 1'b1);
    chk_result("illegal", 14, 4, 8, 1);
    chk_released("illegal");
    beat(4'd3, 1'b1);
    chk_result("illegal_next", 3, 1, 3, 0);
    chk_released("illegal_next");

    // Reset mid-frame after 7 beats
    for (int i = 0; i < 7; i++) beat(4'd5, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", 32'(a_if.in_ready), 32'd0);
    chk("mid_rst_sum",   32'(a_if.out_sum), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_no_valid", 32'(a_if.out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    for (int i = 0; i < 15; i++) beat(4'd1, 1'b0);
    chk("mid_rst_not_early", 32'(a_if.out_valid), 32'd0);
    beat(4'd1, 1'b0);
    chk_result("mid_rst", 16, 16, 1, 0);
    chk_released("mid_rst");

    // FRAME_LEN=1: continuous stream, one result every second cycle
    b_vals[0] = 4'd0; b_vals[1] = 4'd8; b_vals[2] = 4'd3;
    b_vals[3] = 4'd12; b_vals[4] = 4'd5; b_vals[5] = 4'd1;
    b_if.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("fl1_ready", 32'(b_if.in_ready), 32'd1);
      chk("fl1_idle_valid", 32'(b_if.out_valid), 32'd0);
      b_if.in_count = b_vals[k];
      @(posedge clk);
      @(negedge clk);
      chk("fl1_valid", 32'(b_if.out_valid), 32'd1);
      chk("fl1_hold_ready", 32'(b_if.in_ready), 32'd0);
      chk("fl1_sum",   32'(b_if.out_sum), (k == 3) ? 32'd8 : 32'(b_vals[k]));
      chk("fl1_bytes", 32'(b_if.out_bytes), 32'd1);
      chk("fl1_max",   32'(b_if.out_max), (k == 3) ? 32'd8 : 32'(b_vals[k]));
      chk("fl1_err",   32'(b_if.out_err), (k == 3) ? 32'd1 : 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    b_if.in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
